// File: rtl/vga_lcd_pkg.sv
// Shared constants for the VGA/LCD pixel flow block: default geometry and the FILL/RUN state encoding.
package vga_lcd_pkg;

  localparam int DW_DEF   = 12;
  localparam int AW_DEF   = 4;
  localparam int DIVW_DEF = 2;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/vga_lcd_flow_if.sv
// Producer/consumer bundle between crtc/sequencer, the flow block and the pal_dac stage.
interface vga_lcd_flow_if #(
  parameter int DW = 12
) ();

  logic          mem_stb_i;
  logic          mem_ack_i;
  logic          fetch_en;
  logic [DW-1:0] prod_dat_i;
  logic          pix_en;
  logic [DW-1:0] pix_dat_o;

  modport slave (
    input  mem_stb_i, mem_ack_i, prod_dat_i,
    output fetch_en, pix_en, pix_dat_o
  );

  modport master (
    output mem_stb_i, mem_ack_i, prod_dat_i,
    input  fetch_en, pix_en, pix_dat_o
  );

endinterface

// File: rtl/vga_lcd_fifo.sv
// DW x 2**AW FIFO with registered read data and occupancy count; one-cycle read latency.
// Push when full is dropped unless a pop frees the slot in the same cycle.
module vga_lcd_fifo #(
  parameter int DW = 12,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] rdat,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int         DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic [DW-1:0] rdat_q;
  logic          wr_ok, rd_ok;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);
  assign rd_ok = pop & ~empty;
  // Full plus a simultaneous pop still accepts the write: the read sees the old word.
  assign wr_ok = push & (~full | rd_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdat_q  <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) begin
        rptr_q <= rptr_q + 1'b1;
        rdat_q <= mem_q[rptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem_q[wptr_q] <= wdat;
  end

  assign rdat  = rdat_q;
  assign level = level_q;

endmodule

// File: rtl/vga_lcd_flow.sv
// Pixel-rate flow control between sequencer fetches and pal_dac: FIFO, pixel divider, FILL/RUN FSM.
// Pixels appear one cycle after a divider tick; underrun emits BLANK and refills to lwm.
module vga_lcd_flow
  import vga_lcd_pkg::*;
#(
  parameter int            DW    = DW_DEF,
  parameter int            AW    = AW_DEF,
  parameter int            DIVW  = DIVW_DEF,
  parameter logic [DW-1:0] BLANK = {DW{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [DIVW-1:0] div_sel,
  input  logic [AW:0]     lwm,
  input  logic [AW:0]     hwm,
  vga_lcd_flow_if.slave   bus,
  output logic [AW:0]     level,
  output logic            underflow,
  output logic            overflow
);

  logic [0:0]      state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            pix_en_q, pix_en_d;
  logic            blank_sel_q, blank_sel_d;
  logic            underflow_q, underflow_d;
  logic            overflow_q, overflow_d;

  logic            tick, fetch, pop;
  logic            fifo_full, fifo_empty;
  logic [DW-1:0]   fifo_rdat;
  logic [AW:0]     fifo_level;

  assign tick = (cnt_q >= div_sel);

  // Stalled memory cycles hold off new fetches; a completing cycle always pushes.
  always_comb begin
    fetch = 1'b0;
    if (!rst && !clr)
      fetch = (bus.mem_stb_i & bus.mem_ack_i) | ((fifo_level < hwm) & ~bus.mem_stb_i);
  end

  assign pop = (state_q == ST_RUN) & tick & ~fifo_empty & ~clr;

  vga_lcd_fifo #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (fetch),
    .pop   (pop),
    .wdat  (bus.prod_dat_i),
    .rdat  (fifo_rdat),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    pix_en_d    = 1'b0;
    blank_sel_d = blank_sel_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;

    if (fetch && fifo_full && !pop) overflow_d = 1'b1;

    case (state_q)
      ST_FILL: begin
        if (fifo_level >= lwm) state_d = ST_RUN;
      end
      default: begin
        // Emptiness is judged before this cycle's push, so a same-cycle push never bypasses.
        if (tick) begin
          pix_en_d = 1'b1;
          if (fifo_empty) begin
            blank_sel_d = 1'b1;
            underflow_d = 1'b1;
            state_d     = ST_FILL;
          end else begin
            blank_sel_d = 1'b0;
          end
        end
      end
    endcase

    if (clr) begin
      state_d     = ST_FILL;
      cnt_d       = '0;
      pix_en_d    = 1'b0;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      pix_en_q    <= 1'b0;
      blank_sel_q <= 1'b1;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pix_en_q    <= pix_en_d;
      blank_sel_q <= blank_sel_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // The FIFO read register only moves on a pop, so the output holds while pix_en is low.
  assign bus.fetch_en  = fetch;
  assign bus.pix_en    = pix_en_q;
  assign bus.pix_dat_o = blank_sel_q ? BLANK : fifo_rdat;
  assign level         = fifo_level;
  assign underflow     = underflow_q;
  assign overflow      = overflow_q;

endmodule
